// File: rtl/reg_ctrl.sv
// Register-file sequencer: direct loads and two-operand ALU commands (read A, read B, execute, write back).
// Define REG_CTRL_RR_EN for round-robin arbitration between load and command; fixed load priority otherwise.
module reg_ctrl (
    input  logic       clk,
    input  logic       nrst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_opcode,
    input  logic [2:0] cmd_src_a,
    input  logic [2:0] cmd_src_b,
    input  logic [2:0] cmd_dst,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [2:0] ld_reg,
    input  logic [8:0] ld_data,
    output logic       rf_write,
    output logic [2:0] rf_reg_num,
    output logic [2:0] rf_reg_sel,
    output logic [8:0] rf_op,
    input  logic [8:0] rf_reg_val,
    output logic [8:0] alu_a,
    output logic [8:0] alu_b,
    output logic [1:0] alu_opcode,
    input  logic [8:0] alu_result,
    output logic       done,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, LOAD, SELA, SELB, CAPB, EXEC, WB, ERR} state_t;

    state_t     r_state;
    logic       r_rf_write;
    logic [2:0] r_rf_reg_num;
    logic [2:0] r_rf_reg_sel;
    logic [8:0] r_rf_op;
    logic [8:0] r_alu_a;
    logic [8:0] r_alu_b;
    logic [1:0] r_alu_opcode;
    logic       r_done;
    logic       r_err;
    logic       r_busy;
    logic [2:0] r_src_b;
    logic [2:0] r_dst;

    logic       w_idle;
    logic       w_grant_ld;
    logic       w_grant_cmd;
    logic       w_cmd_ok;

    // Only registers 1..4 exist in the register file.
    function automatic logic idx_ok(input logic [2:0] idx);
        return (idx >= 3'd1) && (idx <= 3'd4);
    endfunction

`ifdef REG_CTRL_RR_EN
    logic r_last_ld;

    // Last-grant flag: after a load, a pending command goes next.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last_ld <= 1'b0;
        end else if (ld_ready) begin
            r_last_ld <= 1'b1;
        end else if (cmd_ready) begin
            r_last_ld <= 1'b0;
        end else begin
            r_last_ld <= r_last_ld;
        end
    end
`endif

    // Request arbitration; handshakes only while idle and out of reset.
    always_comb begin
        w_idle = (r_state == IDLE) && nrst;
`ifdef REG_CTRL_RR_EN
        w_grant_ld = ld_valid && (!cmd_valid || !r_last_ld);
`else
        w_grant_ld = ld_valid;
`endif
        w_grant_cmd = cmd_valid && !w_grant_ld;
        w_cmd_ok    = idx_ok(cmd_src_a) && idx_ok(cmd_src_b) && idx_ok(cmd_dst);
    end

    assign ld_ready  = w_idle && w_grant_ld;
    assign cmd_ready = w_idle && w_grant_cmd;

    // Main sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= IDLE;
            r_rf_write   <= 1'b0;
            r_rf_reg_num <= 3'd0;
            r_rf_reg_sel <= 3'd0;
            r_rf_op      <= 9'd0;
            r_alu_a      <= 9'd0;
            r_alu_b      <= 9'd0;
            r_alu_opcode <= 2'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_src_b      <= 3'd0;
            r_dst        <= 3'd0;
        end else begin
            r_rf_write   <= 1'b0;
            r_rf_reg_num <= 3'd0;
            r_rf_reg_sel <= 3'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (ld_ready) begin
                        if (idx_ok(ld_reg)) begin
                            r_state      <= LOAD;
                            r_rf_write   <= 1'b1;
                            r_rf_reg_num <= ld_reg;
                            r_rf_op      <= ld_data;
                            r_done       <= 1'b1;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end else if (cmd_ready) begin
                        if (w_cmd_ok) begin
                            r_state      <= SELA;
                            r_rf_reg_sel <= cmd_src_a;
                            r_alu_opcode <= cmd_opcode;
                            r_src_b      <= cmd_src_b;
                            r_dst        <= cmd_dst;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                SELA: begin
                    r_state      <= SELB;
                    r_rf_reg_sel <= r_src_b;
                end
                // Read data lags the select by one cycle, so src_a data is present during SELB.
                SELB: begin
                    r_state <= CAPB;
                    r_alu_a <= rf_reg_val;
                end
                CAPB: begin
                    r_state <= EXEC;
                    r_alu_b <= rf_reg_val;
                end
                EXEC: begin
                    r_state      <= WB;
                    r_rf_op      <= alu_result;
                    r_rf_write   <= 1'b1;
                    r_rf_reg_num <= r_dst;
                    r_done       <= 1'b1;
                end
                LOAD, WB, ERR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rf_write   = r_rf_write;
    assign rf_reg_num = r_rf_reg_num;
    assign rf_reg_sel = r_rf_reg_sel;
    assign rf_op      = r_rf_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    assign done       = r_done;
    assign err        = r_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_reg_ctrl.sv
// Directed testbench for reg_ctrl with a registered-read register file model and a small ALU model.
module tb_reg_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_opcode;
    logic [2:0] cmd_src_a;
    logic [2:0] cmd_src_b;
    logic [2:0] cmd_dst;
    logic       ld_valid;
    logic       ld_ready;
    logic [2:0] ld_reg;
    logic [8:0] ld_data;
    logic       rf_write;
    logic [2:0] rf_reg_num;
    logic [2:0] rf_reg_sel;
    logic [8:0] rf_op;
    logic [8:0] rf_reg_val = 9'd0;
    logic [8:0] alu_a;
    logic [8:0] alu_b;
    logic [1:0] alu_opcode;
    logic [8:0] alu_result;
    logic       done;
    logic       err;
    logic       busy;

    logic [8:0] rf_mem [0:7] = '{default: 9'd0};
    int         wr_count = 0;
    int         checks   = 0;
    int         errors   = 0;

    always #5 clk = ~clk;

    reg_ctrl dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
        .rf_write(rf_write), .rf_reg_num(rf_reg_num), .rf_reg_sel(rf_reg_sel), .rf_op(rf_op),
        .rf_reg_val(rf_reg_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .done(done), .err(err), .busy(busy)
    );

    // Register file: read data registered one cycle after the select.
    always @(posedge clk) begin
        rf_reg_val <= rf_mem[rf_reg_sel];
        if (rf_write) begin
            rf_mem[rf_reg_num] <= rf_op;
            wr_count <= wr_count + 1;
        end
    end

    // ALU model; opcode 1 is addition.
    always_comb begin
        case (alu_opcode)
            2'd0:    alu_result = alu_a & alu_b;
            2'd1:    alu_result = alu_a + alu_b;
            2'd2:    alu_result = alu_a - alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit want_ld);
        int k;
        k = 0;
        #1;
        while (!(want_ld ? ld_ready : cmd_ready) && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 20) begin
            errors++;
            $display("FAIL ready_timeout: want_ld=%0d no ready after %0d cycles (required within 20)", want_ld, k);
        end
    endtask

    task automatic do_load(input logic [2:0] r, input logic [8:0] d);
        ld_reg   = r;
        ld_data  = d;
        ld_valid = 1'b1;
        wait_ready(1'b1);
        tick();
        ld_valid = 1'b0;
        tick();
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
        cmd_opcode = op;
        cmd_src_a  = a;
        cmd_src_b  = b;
        cmd_dst    = d;
        cmd_valid  = 1'b1;
        wait_ready(1'b0);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        nrst = 1'b0; ld_valid = 1'b1; cmd_valid = 1'b1;
        ld_reg = 3'd2; ld_data = 9'h055;
        cmd_opcode = 2'd1; cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ld_ready, cmd_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b required 00", {ld_ready, cmd_ready});
        end
        checks++;
        if ({rf_write, rf_reg_num, rf_reg_sel, rf_op, alu_a, alu_b, alu_opcode, done, err, busy} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {rf_write, rf_reg_num, rf_reg_sel, rf_op, alu_a, alu_b, alu_opcode, done, err, busy});
        end
        ld_valid = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_load;
        ld_reg = 3'd2; ld_data = 9'h0A5; ld_valid = 1'b1; cmd_valid = 1'b0;
        #1;
        checks++;
        if ({ld_ready, cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL load_ready: got %b required 10", {ld_ready, cmd_ready});
        end
        tick();
        ld_valid = 1'b0;
        checks++;
        if ({rf_write, rf_reg_num, rf_op, done, err, busy} !== {1'b1, 3'd2, 9'h0A5, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_cycle: got w=%b num=%0d op=%h done=%b err=%b busy=%b required 1 2 0a5 1 0 1",
                     rf_write, rf_reg_num, rf_op, done, err, busy);
        end
        tick();
        checks++;
        if ({rf_write, rf_reg_num, done, busy} !== 6'd0) begin
            errors++;
            $display("FAIL load_after: got w=%b num=%0d done=%b busy=%b required all 0", rf_write, rf_reg_num, done, busy);
        end
        checks++;
        if (rf_mem[2] !== 9'h0A5) begin
            errors++;
            $display("FAIL load_mem: got %h required 0a5", rf_mem[2]);
        end
    endtask

    task automatic test_alu;
        do_load(3'd1, 9'd7);
        do_load(3'd3, 9'd5);
        start_cmd(2'd1, 3'd1, 3'd3, 3'd4);
        checks++;
        if ({rf_reg_sel, busy} !== {3'd1, 1'b1}) begin
            errors++;
            $display("FAIL alu_sela: got sel=%0d busy=%b required 1 1", rf_reg_sel, busy);
        end
        tick();
        checks++;
        if (rf_reg_sel !== 3'd3) begin
            errors++;
            $display("FAIL alu_selb: got sel=%0d required 3", rf_reg_sel);
        end
        tick();
        checks++;
        if ({alu_a, rf_reg_sel} !== {9'd7, 3'd0}) begin
            errors++;
            $display("FAIL alu_capa: got alu_a=%0d sel=%0d required 7 0", alu_a, rf_reg_sel);
        end
        tick();
        checks++;
        if ({alu_a, alu_b, alu_opcode, rf_write} !== {9'd7, 9'd5, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL alu_exec: got a=%0d b=%0d op=%0d w=%b required 7 5 1 0", alu_a, alu_b, alu_opcode, rf_write);
        end
        // Write-back lands five cycles after the acceptance cycle.
        tick();
        checks++;
        if ({rf_write, rf_reg_num, rf_op, done, err} !== {1'b1, 3'd4, 9'd12, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL alu_wb: got w=%b num=%0d op=%0d done=%b err=%b required 1 4 12 1 0",
                     rf_write, rf_reg_num, rf_op, done, err);
        end
        tick();
        checks++;
        if ({busy, done, rf_mem[4]} !== {1'b0, 1'b0, 9'd12}) begin
            errors++;
            $display("FAIL alu_done: got busy=%b done=%b mem4=%0d required 0 0 12", busy, done, rf_mem[4]);
        end
    endtask

    task automatic test_err;
        int w0;
        w0 = wr_count;
        start_cmd(2'd0, 3'd1, 3'd2, 3'd0);
        checks++;
        if ({err, done, rf_write, rf_reg_sel, rf_reg_num, busy} !== {1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL err_cmd: got err=%b done=%b w=%b sel=%0d num=%0d busy=%b required 1 0 0 0 0 1",
                     err, done, rf_write, rf_reg_sel, rf_reg_num, busy);
        end
        tick();
        checks++;
        if ({err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL err_after: got err=%b busy=%b required 0 0", err, busy);
        end
        ld_reg = 3'd5; ld_data = 9'h1AA; ld_valid = 1'b1;
        wait_ready(1'b1);
        tick();
        ld_valid = 1'b0;
        checks++;
        if ({err, done, rf_write} !== 3'b100) begin
            errors++;
            $display("FAIL err_load: got err=%b done=%b w=%b required 1 0 0", err, done, rf_write);
        end
        tick();
        checks++;
        if (wr_count !== w0) begin
            errors++;
            $display("FAIL err_no_write: got %0d writes required %0d", wr_count, w0);
        end
    endtask

    task automatic test_same_src;
        do_load(3'd2, 9'h1FF);
        start_cmd(2'd1, 3'd2, 3'd2, 3'd1);
        repeat (3) tick();
        checks++;
        if ({alu_a, alu_b} !== {9'h1FF, 9'h1FF}) begin
            errors++;
            $display("FAIL same_src_ops: got a=%h b=%h required 1ff 1ff", alu_a, alu_b);
        end
        tick();
        checks++;
        if ({rf_write, rf_reg_num, rf_op} !== {1'b1, 3'd1, 9'h1FE}) begin
            errors++;
            $display("FAIL same_src_wb: got w=%b num=%0d op=%h required 1 1 1fe", rf_write, rf_reg_num, rf_op);
        end
        tick();
        checks++;
        if (rf_mem[1] !== 9'h1FE) begin
            errors++;
            $display("FAIL same_src_mem: got %h required 1fe", rf_mem[1]);
        end
    endtask

    task automatic test_reset_mid;
        int w0;
        int k;
        do_load(3'd1, 9'd7);
        do_load(3'd4, 9'h033);
        start_cmd(2'd1, 3'd1, 3'd3, 3'd4);
        repeat (2) tick();
        checks++;
        if ({alu_a, busy} !== {9'd7, 1'b1}) begin
            errors++;
            $display("FAIL mid_capb: got a=%0d busy=%b required 7 1", alu_a, busy);
        end
        w0 = wr_count;
        nrst = 1'b0;
        #1;
        checks++;
        if ({rf_write, rf_reg_num, rf_reg_sel, rf_op, alu_a, alu_b, alu_opcode, done, err, busy, ld_ready, cmd_ready} !== 41'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h required 0",
                     {rf_write, rf_reg_num, rf_reg_sel, rf_op, alu_a, alu_b, alu_opcode, done, err, busy, ld_ready, cmd_ready});
        end
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        repeat (6) tick();
        checks++;
        if ({wr_count == w0, rf_mem[4]} !== {1'b1, 9'h033}) begin
            errors++;
            $display("FAIL mid_no_wb: got writes=%0d mem4=%h required %0d 033", wr_count, rf_mem[4], w0);
        end
        start_cmd(2'd2, 3'd1, 3'd3, 3'd4);
        k = 0;
        while (!done && k < 10) begin
            tick();
            k++;
        end
        checks++;
        if ({done, rf_reg_num, rf_op} !== {1'b1, 3'd4, 9'd2}) begin
            errors++;
            $display("FAIL mid_recover: got done=%b num=%0d op=%0d required 1 4 2", done, rf_reg_num, rf_op);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_ld;
        int         nld;
        int         ncmd;
        bit         got_ld;
        int         k;
`ifdef REG_CTRL_RR_EN
        exp_ld = 4'b0101;
`else
        exp_ld = 4'b0011;
`endif
        nrst = 1'b0;
        #1;
        @(negedge clk);
        nrst = 1'b1;
        tick();
        ld_reg = 3'd1; ld_data = 9'h011;
        cmd_opcode = 2'd0; cmd_src_a = 3'd1; cmd_src_b = 3'd1; cmd_dst = 3'd2;
        ld_valid = 1'b1; cmd_valid = 1'b1;
        nld = 2; ncmd = 2;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            #1;
            while (!(ld_ready || cmd_ready) && k < 20) begin
                tick();
                k++;
            end
            got_ld = ld_ready;
            checks++;
            if (k >= 20 || got_ld !== exp_ld[i]) begin
                errors++;
                $display("FAIL arb_order[%0d]: got load=%b (waited %0d) required load=%b", i, got_ld, k, exp_ld[i]);
            end
            tick();
            if (got_ld) nld--; else ncmd--;
            if (nld <= 0) ld_valid = 1'b0;
            if (ncmd <= 0) cmd_valid = 1'b0;
        end
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if ({busy, rf_mem[2]} !== {1'b0, 9'h011}) begin
            errors++;
            $display("FAIL arb_final: got busy=%b mem2=%h required 0 011", busy, rf_mem[2]);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_alu();
        test_err();
        test_same_src();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
